// File: rtl/sprite_cmd_sender.sv
// Purpose : queues sprite-update requests and serialises them as 32-bit command
//           words to the display components, inserting a buffer-switch command
//           once per vertical blank and toggling the back buffer after it.
// Latency : a request accepted into an empty queue (FSM idle, no frame pending)
//           is on writedata one cycle after acceptance; at most one command per
//           two cycles.
// Backpressure: req_ready drops when the queue is full (even if a pop happens
//           the same cycle) and while reset is asserted.
// Ports   : clk, reset (sync, active-low), vcount (current video line),
//           req_valid/req_ready handshake with req_comp_id/req_child/req_type/
//           req_data fields, writedata/write command output, frame_count
//           (number of buffer switches issued, wraps 255->0).
module sprite_cmd_sender #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  vcount,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_comp_id,
  input  logic [4:0]  req_child,
  input  logic [2:0]  req_type,
  input  logic [12:0] req_data,
  output logic [31:0] writedata,
  output logic        write,
  output logic [7:0]  frame_count
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         EW       = 27;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t      state;
  logic        frame_pending;
  logic        back_buf;
  logic [9:0]  vcount_prev;

  // Request queue: entries packed as {comp_id, child, type, data}.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          vblank_start;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full && reset;
  assign push      = req_valid && req_ready;
  // A pending frame switch has priority over queued updates.
  assign pop       = (state == S_IDLE) && !frame_pending && !empty;
  assign head      = mem[rd_ptr];

  // Rising edge of "vcount is on the blank line", so a held vcount only
  // produces a single switch.
  assign vblank_start = (vcount == VBLANK_LINE) && (vcount_prev != VBLANK_LINE);

  // Storage needs no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_comp_id, req_child, req_type, req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      writedata     <= 32'h0;
      write         <= 1'b0;
      frame_pending <= 1'b0;
      back_buf      <= 1'b1;
      frame_count   <= 8'd0;
      vcount_prev   <= 10'd0;
    end else begin
      vcount_prev <= vcount;
      case (state)
        S_IDLE: begin
          if (frame_pending) begin
            state     <= S_SWITCH;
            writedata <= {6'd0, 5'd0, 4'hF, 3'd0, back_buf, 13'd0};
            write     <= 1'b1;
          end else if (!empty) begin
            state     <= S_SEND;
            writedata <= {head[26:21], head[20:16], 4'h1, head[15:13], back_buf, head[12:0]};
            write     <= 1'b1;
          end else begin
            writedata <= 32'h0;
            write     <= 1'b0;
          end
        end
        S_SEND: begin
          state     <= S_IDLE;
          writedata <= 32'h0;
          write     <= 1'b0;
        end
        S_SWITCH: begin
          // The switch word went out with the old back_buf; flip afterwards.
          state       <= S_IDLE;
          writedata   <= 32'h0;
          write       <= 1'b0;
          back_buf    <= ~back_buf;
          frame_count <= frame_count + 8'd1;
        end
        default: begin
          state     <= S_IDLE;
          writedata <= 32'h0;
          write     <= 1'b0;
        end
      endcase
      // A new vblank on the same edge as the switch completes is a fresh frame
      // and must not be lost, so the set wins over the clear.
      if (state == S_SWITCH) frame_pending <= 1'b0;
      if (vblank_start)      frame_pending <= 1'b1;
    end
  end

endmodule

// File: doc/sprite_cmd_sender.md
SPRITE_CMD_SENDER -- requirements
Module: sprite_cmd_sender

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the request queue depth (power of two, 2..32).
REQ-002 Parameter VBLANK_LINE, default 10'd480, SHALL set the vcount value that marks vertical-blank start.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-005 vcount  input  10  SHALL be the current video line from the VGA timing counter.
REQ-006 req_valid  input  1  SHALL flag a sprite-update request.
REQ-007 req_ready  output  1  SHALL flag that the queue accepts a request this cycle.
REQ-008 req_comp_id  input  6  SHALL be the target component ID.
REQ-009 req_child  input  5  SHALL be the target child index.
REQ-010 req_type  input  3  SHALL be the data type (3'b001 = pattern select).
REQ-011 req_data  input  13  SHALL be the payload: [12] visible, [11] flip, [9:0] coordinate/shift, [4:0] pattern index.
REQ-012 writedata  output  32  SHALL be the registered command word to all display components.
REQ-013 write  output  1  SHALL pulse high for exactly the cycle a non-idle command is on writedata.
REQ-014 frame_count  output  8  SHALL count issued buffer switches, wrapping 255->0.

Function
REQ-015 Word format SHALL be [31:26] comp_id, [25:21] child, [20:17] ctrl, [16:14] type, [13] buffer, [12:0] data.
REQ-016 ctrl codes SHALL be 4'h1 = sprite update, 4'hF = buffer switch, 4'h0 = idle; the idle word SHALL be 32'h0.
REQ-017 A request SHALL be enqueued on a posedge where req_valid && req_ready; req_ready SHALL be !full && reset==1.
REQ-018 When the queue is full, req_ready SHALL be 0 even if a pop occurs the same cycle.
REQ-019 A simultaneous push and pop on a non-full queue SHALL both occur, with occupancy unchanged.
REQ-020 Internal bit back_buf SHALL select the buffer written by update words; front buffer = ~back_buf.
REQ-021 vblank_start SHALL be detected when vcount==VBLANK_LINE and the registered previous vcount != VBLANK_LINE; it SHALL set sticky flag frame_pending.
REQ-022 FSM states SHALL be IDLE, SEND, SWITCH.
REQ-023 In IDLE with frame_pending=1, next state SHALL be SWITCH, taking priority over a non-empty queue.
REQ-024 In IDLE with frame_pending=0 and queue non-empty, next state SHALL be SEND and the head entry SHALL be popped.
REQ-025 Entering SEND SHALL register writedata = {comp_id, child, 4'h1, type, back_buf, data} and write=1 for one cycle.
REQ-026 Entering SWITCH SHALL register writedata = {6'd0, 5'd0, 4'hF, 3'd0, back_buf, 13'd0} and write=1 for one cycle.
REQ-027 On leaving SWITCH, back_buf SHALL toggle, frame_pending SHALL clear, and frame_count SHALL increment.
REQ-028 From SEND or SWITCH the FSM SHALL return to IDLE, driving writedata=32'h0 and write=0 for at least one cycle, giving a maximum of one command per 2 cycles.
REQ-029 A vblank_start arriving during SEND SHALL be serviced in the next IDLE cycle; the current word SHALL complete unchanged.
REQ-030 Entries still queued at switch time SHALL be sent after the switch, targeting the new back_buf.
REQ-031 Latency SHALL be: a request accepted at edge N into an empty queue with the FSM in IDLE and no pending frame appears on writedata after edge N+1.

Reset
REQ-032 While reset==0 at a posedge: writedata=32'h0, write=0, state=IDLE, queue empty, frame_pending=0, back_buf=1, frame_count=0, previous-vcount register=0.
REQ-033 Reset asserted mid-SEND or mid-SWITCH SHALL abort the word, discard all queued requests, and take effect on that same edge.

Verification
REQ-034 Single request (comp 6'h0A, child 1, type 1, data 13'h1001) after reset -> writedata=32'h2822_7001 for 1 cycle with write=1, then 32'h0.
REQ-035 vcount stepping 479->480 with empty queue -> one word 32'h001E_2000, frame_count=1, back_buf=0; a later update word has bit13=0.
REQ-036 Push 9 requests back-to-back with FIFO_DEPTH=8 and the FSM stalled by a pending switch -> req_ready=0 after 8 accepts; all accepted entries are sent in order, none lost.
REQ-037 vblank_start with 3 queued entries -> switch word first, then 3 updates carrying the new back_buf value.
REQ-038 vcount held at 480 for 800 cycles -> exactly one switch.
REQ-039 frame_count reaches 255 and one more switch occurs -> frame_count wraps to 0.
REQ-040 Reset pulled low during SEND with 4 entries queued -> next cycle writedata=0, write=0, req_ready=0; after release req_ready=1, queue empty, back_buf=1.
